// File: rtl/mau_pkg.sv
// Shared definitions for the load/store stage: opcodes, FSM states, exception codes, lane masks.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mau_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SC  = 6'h38;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd3;

  // Byte-enable masks; bit3 covers data bits [31:24].
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL,
      OP_SB, OP_SH, OP_SW, OP_SC: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic size_t op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    op_signed = (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mau_lane_steer.sv
// Byte-lane steering: byte enables, store replication, load extraction/extension, misalign flag.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
module mau_lane_steer
  import mau_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  size_t       size;
  logic        sgn;
  logic [1:0]  byte_lane;
  logic        half_upper;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Map byte/half offsets onto physical lanes according to endianness.
  always_comb begin
    size       = op_size(opcode);
    sgn        = op_signed(opcode);
    byte_lane  = BIG_ENDIAN ? (2'd3 - addr_lo) : addr_lo;
    half_upper = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    rd_byte    = rdata[{byte_lane, 3'b000} +: 8];
    rd_half    = half_upper ? rdata[31:16] : rdata[15:0];
  end

  // Select enables, replicate store data and extend load data by access size.
  always_comb begin
    be        = BE_WORD;
    wdata     = store_data;
    rdata_ext = rdata;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = BE_BYTE0 << byte_lane;
        wdata     = {4{store_data[7:0]}};
        rdata_ext = {{24{sgn & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        be        = half_upper ? BE_HALF_HI : BE_HALF_LO;
        wdata     = {2{store_data[15:0]}};
        rdata_ext = {{16{sgn & rd_half[15]}}, rd_half};
        misalign  = addr_lo[0];
      end
      default: begin
        misalign  = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: single-outstanding req/ack memory access with LL/SC link tracking.
// Latency: done 2 cycles after start when ack arrives in the first req cycle; 1 cycle on exception or SC fail.
// Backpressure: busy blocks new starts; mem_req holds until mem_ack or TIMEOUT_CYCLES elapse.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          BIG_ENDIAN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        link_clear,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_result,
  output logic [1:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      state, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic        link_valid, link_valid_d;
  logic [29:0] link_addr, link_addr_d;

  logic        busy_d, done_d, req_d, we_d;
  logic [31:0] result_d, maddr_d, wdata_d;
  logic [1:0]  exc_d;
  logic [3:0]  be_d;

  logic [5:0]  steer_op;
  logic [1:0]  steer_lo;
  logic [3:0]  steer_be;
  logic [31:0] steer_wdata, steer_rdata;
  logic        steer_misalign;

  // Steer on live inputs while idle (request decode), on latched request otherwise (load return).
  always_comb begin
    steer_op = (state == ST_IDLE) ? opcode    : op_q;
    steer_lo = (state == ST_IDLE) ? addr[1:0] : addr_q[1:0];
  end

  mau_lane_steer #(.BIG_ENDIAN(BIG_ENDIAN)) u_steer (
    .opcode     (steer_op),
    .addr_lo    (steer_lo),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (steer_be),
    .wdata      (steer_wdata),
    .rdata_ext  (steer_rdata),
    .misalign   (steer_misalign)
  );

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d      = state;
    op_d         = op_q;
    addr_d       = addr_q;
    cnt_d        = cnt;
    link_valid_d = link_valid;
    link_addr_d  = link_addr;
    busy_d       = busy;
    done_d       = 1'b0;
    result_d     = load_result;
    exc_d        = exc_code;
    req_d        = mem_req;
    we_d         = mem_we;
    maddr_d      = mem_addr;
    wdata_d      = mem_wdata;
    be_d         = mem_be;

    case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d   = opcode;
          addr_d = addr;
          busy_d = 1'b1;
          if (!op_legal(opcode)) begin
            state_d  = ST_RESP;
            done_d   = 1'b1;
            exc_d    = EXC_ILLEGAL;
            result_d = 32'd0;
          end else if (steer_misalign) begin
            state_d  = ST_RESP;
            done_d   = 1'b1;
            exc_d    = EXC_MISALIGN;
            result_d = 32'd0;
          end else if ((opcode == OP_SC) && !(link_valid && (link_addr == addr[31:2]))) begin
            // SC with a broken link fails without touching memory.
            state_d  = ST_RESP;
            done_d   = 1'b1;
            exc_d    = EXC_NONE;
            result_d = 32'd0;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = op_is_store(opcode);
            maddr_d = {addr[31:2], 2'b00};
            be_d    = steer_be;
            wdata_d = op_is_store(opcode) ? steer_wdata : 32'd0;
          end
        end
      end

      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          exc_d   = EXC_NONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          if (op_is_store(op_q)) begin
            result_d = (op_q == OP_SC) ? 32'd1 : 32'd0;
            if (link_addr == addr_q[31:2]) begin
              link_valid_d = 1'b0;
            end
          end else begin
            result_d = steer_rdata;
            if (op_q == OP_LL) begin
              link_valid_d = 1'b1;
              link_addr_d  = addr_q[31:2];
            end
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ST_RESP;
          done_d   = 1'b1;
          exc_d    = EXC_TIMEOUT;
          result_d = 32'd0;
          req_d    = 1'b0;
          we_d     = 1'b0;
          be_d     = 4'b0000;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase

    // An external invalidate overrides a simultaneous LL completion.
    if (link_clear) begin
      link_valid_d = 1'b0;
    end
  end

  // State, link and output registers; reset abandons any access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= 6'd0;
      addr_q      <= 32'd0;
      cnt         <= '0;
      link_valid  <= 1'b0;
      link_addr   <= 30'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_result <= 32'd0;
      exc_code    <= EXC_NONE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_be      <= 4'b0000;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      cnt         <= cnt_d;
      link_valid  <= link_valid_d;
      link_addr   <= link_addr_d;
      busy        <= busy_d;
      done        <= done_d;
      load_result <= result_d;
      exc_code    <= exc_d;
      mem_req     <= req_d;
      mem_we      <= we_d;
      mem_addr    <= maddr_d;
      mem_wdata   <= wdata_d;
      mem_be      <= be_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for the load/store stage with hand-computed expectations.
// Latency: n/a.
// Backpressure: models a memory that acks on a chosen cycle or never.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        link_clear;
  logic        busy;
  logic        done;
  logic [31:0] load_result;
  logic [1:0]  exc_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  int          dc, rc;
  logic [3:0]  obe;
  logic [31:0] owd, oma, ores;
  logic        owe;
  logic [1:0]  oex;
  logic        seen_done;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .BIG_ENDIAN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .addr        (addr),
    .store_data  (store_data),
    .link_clear  (link_clear),
    .busy        (busy),
    .done        (done),
    .load_result (load_result),
    .exc_code    (exc_code),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at the current cycle (cycle 0), ack on cycle ack_at (-1: never),
  // record the first request beat and the completion; returns in the following idle cycle.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] rd,
                        output int done_cyc, output int req_cnt, output logic [3:0] be,
                        output logic [31:0] wd, output logic [31:0] ma, output logic we,
                        output logic [31:0] res, output logic [1:0] ex);
    start      = 1'b1;
    opcode     = op;
    addr       = a;
    store_data = d;
    done_cyc   = -1;
    req_cnt    = 0;
    be  = 4'h0;  wd = 32'h0;  ma = 32'h0;  we = 1'b0;
    res = 32'hFFFF_FFFF;  ex = 2'b11;
    for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
      tick();
      start   = 1'b0;
      mem_ack = 1'b0;
      if (done) begin
        done_cyc = c;
        res      = load_result;
        ex       = exc_code;
      end
      if (mem_req) begin
        if (req_cnt == 0) begin
          be = mem_be;  wd = mem_wdata;  ma = mem_addr;  we = mem_we;
        end
        req_cnt++;
        if (c == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;  start = 1'b0;  opcode = 6'h0;  addr = 32'h0;  store_data = 32'h0;
    link_clear = 1'b0;  mem_ack = 1'b0;  mem_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_req",    32'(mem_req), 32'd0);
    chk("rst_result", load_result, 32'd0);
    chk("rst_be",     32'(mem_be), 32'd0);

    // LW aligned, immediate ack
    run_op(OP_LW, 32'h100, 32'h0, 1, 32'hDEADBEEF, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("lw_done_cyc", dc, 2);
    chk("lw_addr",     oma, 32'h100);
    chk("lw_be",       32'(obe), 32'hF);
    chk("lw_we",       32'(owe), 32'd0);
    chk("lw_result",   ores, 32'hDEADBEEF);
    chk("lw_exc",      32'(oex), 32'd0);

    // LB / LBU on byte offset 3 (big-endian: bits[7:0])
    run_op(OP_LB, 32'h103, 32'h0, 1, 32'h123456F0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("lb_be",     32'(obe), 32'h1);
    chk("lb_addr",   oma, 32'h100);
    chk("lb_result", ores, 32'hFFFFFFF0);
    run_op(OP_LBU, 32'h103, 32'h0, 1, 32'h123456F0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("lbu_result", ores, 32'h000000F0);

    // LH lower lane sign-extends, LHU upper lane zero-extends
    run_op(OP_LH, 32'h102, 32'h0, 1, 32'h12348001, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("lh_be",     32'(obe), 32'h3);
    chk("lh_result", ores, 32'hFFFF8001);
    run_op(OP_LHU, 32'h100, 32'h0, 1, 32'h80010000, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("lhu_be",     32'(obe), 32'hC);
    chk("lhu_result", ores, 32'h00008001);

    // Stores: lane replication and enables
    run_op(OP_SH, 32'h202, 32'h0000ABCD, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("sh_be",     32'(obe), 32'h3);
    chk("sh_wdata",  owd, 32'hABCDABCD);
    chk("sh_we",     32'(owe), 32'd1);
    chk("sh_addr",   oma, 32'h200);
    chk("sh_result", ores, 32'd0);
    run_op(OP_SB, 32'h201, 32'h1234565A, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("sb_be",    32'(obe), 32'h4);
    chk("sb_wdata", owd, 32'h5A5A5A5A);

    // Misaligned accesses complete in one cycle with no request
    run_op(OP_SH, 32'h201, 32'h0000ABCD, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("sh_mis_done_cyc", dc, 1);
    chk("sh_mis_exc",      32'(oex), 32'd1);
    chk("sh_mis_req",      rc, 0);
    run_op(OP_LW, 32'h102, 32'h0, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("lw_mis_exc", 32'(oex), 32'd1);
    chk("lw_mis_req", rc, 0);

    // LL then SC succeeds, second SC fails
    run_op(OP_LL, 32'h300, 32'h0, 1, 32'h11112222, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("ll_result", ores, 32'h11112222);
    run_op(OP_SC, 32'h300, 32'h55, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("sc1_req",    rc, 1);
    chk("sc1_we",     32'(owe), 32'd1);
    chk("sc1_wdata",  owd, 32'h55);
    chk("sc1_result", ores, 32'd1);
    run_op(OP_SC, 32'h300, 32'h66, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("sc2_done_cyc", dc, 1);
    chk("sc2_req",      rc, 0);
    chk("sc2_result",   ores, 32'd0);
    chk("sc2_exc",      32'(oex), 32'd0);

    // link_clear breaks a fresh link
    run_op(OP_LL, 32'h400, 32'h0, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    link_clear = 1'b1;
    tick();
    link_clear = 1'b0;
    run_op(OP_SC, 32'h400, 32'h77, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("sc_clr_req",    rc, 0);
    chk("sc_clr_result", ores, 32'd0);

    // Timeout: request held exactly 4 cycles, then exc=2
    run_op(OP_LW, 32'h500, 32'h0, -1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("to_req_cycles", rc, 4);
    chk("to_done_cyc",   dc, 5);
    chk("to_exc",        32'(oex), 32'd2);
    chk("to_result",     ores, 32'd0);
    // Late ack in idle has no effect
    mem_ack = 1'b1;  mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_done", 32'(done), 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);

    // Illegal opcode
    run_op(6'h3F, 32'h100, 32'h0, 1, 32'h0, dc, rc, obe, owd, oma, owe, ores, oex);
    chk("ill_done_cyc", dc, 1);
    chk("ill_exc",      32'(oex), 32'd3);
    chk("ill_req",      rc, 0);

    // Start while busy is ignored
    start = 1'b1;  opcode = OP_LW;  addr = 32'h100;
    tick();
    opcode = OP_SW;  addr = 32'h500;  store_data = 32'h77;
    chk("busy_flag", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    chk("busy_we",   32'(mem_we), 32'd0);
    chk("busy_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;  mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    chk("busy_done",   32'(done), 32'd1);
    chk("busy_result", load_result, 32'hCAFEF00D);
    tick();
    tick();
    chk("busy_no_req", 32'(mem_req), 32'd0);
    chk("busy_idle",   32'(busy), 32'd0);

    // Reset during ACCESS drops the request immediately, no done
    start = 1'b1;  opcode = OP_LW;  addr = 32'h100;
    tick();
    start = 1'b0;
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_req_after", 32'(mem_req), 32'd0);
    tick();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || mem_req) seen_done = 1'b1;
    end
    chk("rst_mid_no_done", 32'(seen_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
